mmio_slot_ctrl: RTL and testbench

MMIO_SLOT_CTRL -- requirements
Module: mmio_slot_ctrl

---
 rtl/mmio_slot_ctrl.sv | 147 ++++++++++++++
 tb/tb_mmio_slot_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_slot_ctrl.sv
// mmio_slot_ctrl: fans FPro MMIO requests out to N_SLOT register slots and returns registered read data.
// Latency: slot strobes 1 cycle after request acceptance; mmio_rd_data/mmio_rd_valid exactly 2 cycles after.
// Backpressure: none; one request per cycle is accepted unconditionally, back to back, never stalled.
//
// Ports:
//   clk, reset                       sole clock (rising edge), synchronous active-high reset
//   mmio_cs/wr/rd, mmio_addr,        FPro bus request: word address = {ignored, slot[SW], reg[REG_AW]}
//   mmio_wr_data                     write data
//   mmio_rd_data, mmio_rd_valid      registered read data and its one-cycle update pulse
//   slot_cs/mem_rd/mem_wr_array      per-slot one-cycle strobes (one-hot, only for implemented slots)
//   slot_reg_addr, slot_wr_data      shared register address / write data, held until the next request
//   slot_rd_data_flat                slot i read word at bits [32i+31:32i]
//   err_clr, err_count, err_addr     fault capture for requests to unimplemented slots; these ports
//                                    exist only when the macro MMIO_ERR_CAPTURE_EN is defined
module mmio_slot_ctrl #(
  parameter int                N_SLOT  = 64,
  parameter int                REG_AW  = 5,
  parameter logic [N_SLOT-1:0] SLOT_EN = '1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mmio_cs,
  input  logic                   mmio_wr,
  input  logic                   mmio_rd,
  input  logic [20:0]            mmio_addr,
  input  logic [31:0]            mmio_wr_data,
  output logic [31:0]            mmio_rd_data,
  output logic                   mmio_rd_valid,
  output logic [N_SLOT-1:0]      slot_cs_array,
  output logic [N_SLOT-1:0]      slot_mem_rd_array,
  output logic [N_SLOT-1:0]      slot_mem_wr_array,
  output logic [REG_AW-1:0]      slot_reg_addr,
  output logic [31:0]            slot_wr_data,
  input  logic [32*N_SLOT-1:0]   slot_rd_data_flat
`ifdef MMIO_ERR_CAPTURE_EN
  ,
  input  logic                   err_clr,
  output logic [15:0]            err_count,
  output logic [20:0]            err_addr
`endif
);

  localparam int SW = $clog2(N_SLOT);
  localparam logic [N_SLOT-1:0] SLOT0_BIT = N_SLOT'(1);

  // ---------------------------------------------------------------------------
  // Request decode (combinational, cycle T)
  // ---------------------------------------------------------------------------
  logic              req_acc;
  logic              req_is_wr;
  logic              req_is_rd;
  logic [SW-1:0]     req_slot;
  logic              req_impl;
  logic [N_SLOT-1:0] req_onehot;

  assign req_acc    = mmio_cs & (mmio_wr | mmio_rd);
  // A simultaneous write and read strobe is treated as a write only.
  assign req_is_wr  = req_acc & mmio_wr;
  assign req_is_rd  = req_acc & mmio_rd & ~mmio_wr;
  assign req_slot   = mmio_addr[REG_AW+SW-1:REG_AW];
  assign req_impl   = SLOT_EN[req_slot];
  // Unimplemented slots decode to no strobe at all, so their writes vanish.
  assign req_onehot = req_impl ? (SLOT0_BIT << req_slot) : '0;

  // ---------------------------------------------------------------------------
  // Stage 1 (edge T+1): slot strobes, shared address/data, read bookkeeping
  // ---------------------------------------------------------------------------
  logic          rd_pend_q;
  logic [SW-1:0] rd_slot_q;
  logic          rd_impl_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cs_array     <= '0;
      slot_mem_wr_array <= '0;
      slot_mem_rd_array <= '0;
      slot_reg_addr     <= '0;
      slot_wr_data      <= '0;
      rd_pend_q         <= 1'b0;
      rd_slot_q         <= '0;
      rd_impl_q         <= 1'b0;
    end else begin
      slot_cs_array     <= req_acc   ? req_onehot : '0;
      slot_mem_wr_array <= req_is_wr ? req_onehot : '0;
      slot_mem_rd_array <= req_is_rd ? req_onehot : '0;
      if (req_acc) begin
        slot_reg_addr <= mmio_addr[REG_AW-1:0];
        slot_wr_data  <= mmio_wr_data;
      end
      // Reads to unimplemented slots still complete, returning zero.
      rd_pend_q <= req_is_rd;
      rd_slot_q <= req_slot;
      rd_impl_q <= req_impl;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 (edge T+2): capture the selected slot's word presented during T+1
  // ---------------------------------------------------------------------------
  logic [31:0] rd_word;

  assign rd_word = rd_impl_q ? slot_rd_data_flat[{rd_slot_q, 5'b0} +: 32] : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      mmio_rd_data  <= '0;
      mmio_rd_valid <= 1'b0;
    end else begin
      mmio_rd_valid <= rd_pend_q;
      if (rd_pend_q) begin
        mmio_rd_data <= rd_word;
      end
    end
  end

`ifdef MMIO_ERR_CAPTURE_EN
  // ---------------------------------------------------------------------------
  // Fault capture: accepted requests to unimplemented slots
  // ---------------------------------------------------------------------------
  logic fault;

  assign fault = req_acc & ~req_impl;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= '0;
      err_addr  <= '0;
    end else if (fault) begin
      // A clear coinciding with a new fault restarts the count at that fault.
      if (err_clr) begin
        err_count <= 16'd1;
      end else if (err_count != 16'hFFFF) begin
        err_count <= err_count + 16'd1;
      end
      err_addr <= mmio_addr;
    end else if (err_clr) begin
      err_count <= '0;
      err_addr  <= '0;
    end
  end
`else
  // Address bits above the slot field are intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^mmio_addr[20:REG_AW+SW];
`endif

endmodule

// File: tb/tb_mmio_slot_ctrl.sv
// tb_mmio_slot_ctrl: directed scenarios plus randomized traffic against a cycle-level reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
`timescale 1ns/1ps
module tb_mmio_slot_ctrl;

  localparam int          NS         = 64;
  localparam int          RAW        = 5;
  localparam logic [63:0] SLOT_EN_TB = 64'hFFFF_FEFF_FFFF_FDFF;  // slots 9 and 40 unimplemented

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              mmio_cs, mmio_wr, mmio_rd;
  logic [20:0]       mmio_addr;
  logic [31:0]       mmio_wr_data;
  logic [31:0]       mmio_rd_data;
  logic              mmio_rd_valid;
  logic [NS-1:0]     slot_cs_array, slot_mem_rd_array, slot_mem_wr_array;
  logic [RAW-1:0]    slot_reg_addr;
  logic [31:0]       slot_wr_data;
  logic [32*NS-1:0]  slot_rd_data_flat;
`ifdef MMIO_ERR_CAPTURE_EN
  logic              err_clr;
  logic [15:0]       err_count;
  logic [20:0]       err_addr;
`endif

  logic [31:0] slot_data [NS];

  for (genvar g = 0; g < NS; g++) begin : g_flat
    assign slot_rd_data_flat[32*g +: 32] = slot_data[g];
  end

  mmio_slot_ctrl #(
    .N_SLOT (NS),
    .REG_AW (RAW),
    .SLOT_EN(SLOT_EN_TB)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .mmio_cs          (mmio_cs),
    .mmio_wr          (mmio_wr),
    .mmio_rd          (mmio_rd),
    .mmio_addr        (mmio_addr),
    .mmio_wr_data     (mmio_wr_data),
    .mmio_rd_data     (mmio_rd_data),
    .mmio_rd_valid    (mmio_rd_valid),
    .slot_cs_array    (slot_cs_array),
    .slot_mem_rd_array(slot_mem_rd_array),
    .slot_mem_wr_array(slot_mem_wr_array),
    .slot_reg_addr    (slot_reg_addr),
    .slot_wr_data     (slot_wr_data),
    .slot_rd_data_flat(slot_rd_data_flat)
`ifdef MMIO_ERR_CAPTURE_EN
    ,
    .err_clr          (err_clr),
    .err_count        (err_count),
    .err_addr         (err_addr)
`endif
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: per-cycle record of what was driven, outputs derived from
  // the request one cycle back (strobes) and two cycles back (read return).
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic        rst;
    logic        cs;
    logic        wr;
    logic        rd;
    logic        clr;
    logic [20:0] addr;
    logic [31:0] wd;
  } req_t;

  req_t        p, pp;               // inputs of previous cycle and the one before
  logic [31:0] p_data [NS];         // slot read data presented in previous cycle
  bit          rand_data;

  logic [NS-1:0]  exp_cs, exp_wr, exp_rd;
  logic [RAW-1:0] exp_ra;
  logic [31:0]    exp_wd, exp_rdd;
  logic           exp_vld;
  int             exp_cnt;
  logic [20:0]    exp_eaddr;

  function automatic void model_edge();
    logic [5:0] s, s2;
    bit         acc, rd2;
    s   = p.addr[10:5];
    acc = p.cs && (p.wr || p.rd);
    if (p.rst) begin
      exp_cs = '0; exp_wr = '0; exp_rd = '0; exp_ra = '0; exp_wd = '0;
      exp_vld = 1'b0; exp_rdd = '0; exp_cnt = 0; exp_eaddr = '0;
    end else begin
      exp_cs = '0; exp_wr = '0; exp_rd = '0;
      if (acc && SLOT_EN_TB[s]) begin
        exp_cs[s] = 1'b1;
        if (p.wr) exp_wr[s] = 1'b1;
        else      exp_rd[s] = 1'b1;
      end
      if (acc) begin
        exp_ra = p.addr[4:0];
        exp_wd = p.wd;
      end
      rd2     = !pp.rst && pp.cs && pp.rd && !pp.wr;
      exp_vld = rd2;
      if (rd2) begin
        s2      = pp.addr[10:5];
        exp_rdd = SLOT_EN_TB[s2] ? p_data[s2] : 32'h0;
      end
      if (acc && !SLOT_EN_TB[s]) begin
        exp_cnt   = p.clr ? 1 : ((exp_cnt < 65535) ? exp_cnt + 1 : 65535);
        exp_eaddr = p.addr;
      end else if (p.clr) begin
        exp_cnt   = 0;
        exp_eaddr = '0;
      end
    end
  endfunction

  // One clock: check the outputs of the edge just taken, then drive the next cycle.
  task automatic step(input bit r, input bit cs, input bit wr, input bit rd,
                      input logic [20:0] a, input logic [31:0] wd, input bit clr);
    @(posedge clk);
    #1;
    model_edge();
    chk("slot_cs", slot_cs_array, exp_cs);
    chk("slot_wr", slot_mem_wr_array, exp_wr);
    chk("slot_rd", slot_mem_rd_array, exp_rd);
    chk("reg_addr", 64'(slot_reg_addr), 64'(exp_ra));
    chk("wr_data", 64'(slot_wr_data), 64'(exp_wd));
    chk("rd_valid", 64'(mmio_rd_valid), 64'(exp_vld));
    chk("rd_data", 64'(mmio_rd_data), 64'(exp_rdd));
`ifdef MMIO_ERR_CAPTURE_EN
    chk("err_count", 64'(err_count), 64'(exp_cnt));
    chk("err_addr", 64'(err_addr), 64'(exp_eaddr));
    err_clr = clr;
`endif
    reset        = r;
    mmio_cs      = cs;
    mmio_wr      = wr;
    mmio_rd      = rd;
    mmio_addr    = a;
    mmio_wr_data = wd;
    if (rand_data) begin
      for (int i = 0; i < NS; i++) slot_data[i] = $urandom;
    end
    pp = p;
    p.rst = r; p.cs = cs; p.wr = wr; p.rd = rd; p.clr = clr; p.addr = a; p.wd = wd;
    p_data = slot_data;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 21'h0, 32'h0, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b1; mmio_cs = 1'b0; mmio_wr = 1'b0; mmio_rd = 1'b0;
    mmio_addr = '0; mmio_wr_data = '0;
`ifdef MMIO_ERR_CAPTURE_EN
    err_clr = 1'b0;
`endif
    for (int i = 0; i < NS; i++) slot_data[i] = 32'h0;
    p = '0; p.rst = 1'b1;
    pp = p;
    p_data = slot_data;
    rand_data = 1'b0;
    exp_cnt = 0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, 21'h0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 21'h0, 32'h0, 1'b0);
    chk("rst_rd_data", 64'(mmio_rd_data), 64'h0);
    chk("rst_cs", slot_cs_array, 64'h0);

    // Read slot 3 reg 2
    slot_data[3] = 32'hA5A5_0001;
    step(1'b0, 1'b1, 1'b0, 1'b1, 21'h62, 32'h0, 1'b0);
    idle();
    chk("r3_cs", slot_cs_array, 64'h8);
    chk("r3_rdstb", slot_mem_rd_array, 64'h8);
    chk("r3_regaddr", 64'(slot_reg_addr), 64'h2);
    idle();
    chk("r3_cs_gone", slot_cs_array, 64'h0);
    chk("r3_vld", 64'(mmio_rd_valid), 64'h1);
    chk("r3_data", 64'(mmio_rd_data), 64'hA5A5_0001);
    idle();
    chk("r3_vld_once", 64'(mmio_rd_valid), 64'h0);
    chk("r3_data_hold", 64'(mmio_rd_data), 64'hA5A5_0001);

    // Write slot 2 reg 0
    step(1'b0, 1'b1, 1'b1, 1'b0, 21'h40, 32'h1234, 1'b0);
    idle();
    chk("w2_wrstb", slot_mem_wr_array, 64'h4);
    chk("w2_data", 64'(slot_wr_data), 64'h1234);
    chk("w2_regaddr", 64'(slot_reg_addr), 64'h0);
    idle();
    chk("w2_novld", 64'(mmio_rd_valid), 64'h0);
    chk("w2_data_hold", 64'(slot_wr_data), 64'h1234);

    // Four back-to-back reads of slots 0..3
    for (int i = 0; i < 4; i++) slot_data[i] = 32'h1111_0000 + 32'(i);
    step(1'b0, 1'b1, 1'b0, 1'b1, 21'h000, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 21'h020, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i < 2) step(1'b0, 1'b1, 1'b0, 1'b1, 21'(32'h40 + 32'(i) * 32'h20), 32'h0, 1'b0);
      else       idle();
      chk("b2b_vld", 64'(mmio_rd_valid), 64'h1);
      chk("b2b_data", 64'(mmio_rd_data), 64'h1111_0000 + 64'(i));
    end

    // Read of unimplemented slot 9
    step(1'b0, 1'b1, 1'b0, 1'b1, 21'h120, 32'h0, 1'b0);
    idle();
    chk("u9_cs", slot_cs_array, 64'h0);
    idle();
    chk("u9_vld", 64'(mmio_rd_valid), 64'h1);
    chk("u9_data", 64'(mmio_rd_data), 64'h0);
`ifdef MMIO_ERR_CAPTURE_EN
    chk("u9_errcnt", 64'(err_count), 64'h1);
    chk("u9_erraddr", 64'(err_addr), 64'h120);
`endif

    // Write and read together to slot 5
    step(1'b0, 1'b1, 1'b1, 1'b1, 21'hA0, 32'hCAFE, 1'b0);
    idle();
    chk("wr_rd_wr", slot_mem_wr_array, 64'h20);
    chk("wr_rd_rd", slot_mem_rd_array, 64'h0);
    idle();
    chk("wr_rd_novld", 64'(mmio_rd_valid), 64'h0);

    // Reset while a read is in flight
    step(1'b0, 1'b1, 1'b0, 1'b1, 21'h62, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 21'h0, 32'h0, 1'b0);
    idle();
    chk("rstfl_vld", 64'(mmio_rd_valid), 64'h0);
    chk("rstfl_data", 64'(mmio_rd_data), 64'h0);
    chk("rstfl_cs", slot_cs_array, 64'h0);
    chk("rstfl_wd", 64'(slot_wr_data), 64'h0);

    // Randomized traffic, slot data changing every cycle
    rand_data = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(99) == 0),
           ($urandom_range(3) != 0),
           1'($urandom), 1'($urandom),
           21'($urandom),
           $urandom,
           ($urandom_range(19) == 0));
    end
    rand_data = 1'b0;

`ifdef MMIO_ERR_CAPTURE_EN
    // Saturation of the fault counter, then clear
    step(1'b0, 1'b0, 1'b0, 1'b0, 21'h0, 32'h0, 1'b1);
    for (int n = 0; n < 65540; n++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 21'h120, 32'h0, 1'b0);
    end
    idle();
    chk("sat_count", 64'(err_count), 64'hFFFF);
    step(1'b0, 1'b0, 1'b0, 1'b0, 21'h0, 32'h0, 1'b1);
    idle();
    chk("clr_count", 64'(err_count), 64'h0);
    chk("clr_addr", 64'(err_addr), 64'h0);
`endif

    idle();
    idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
